// File: rtl/memio_pkg.sv
// rtl/memio_pkg.sv - shared types and IO address map for the memory/IO arbiter
package memio_pkg;

  typedef enum logic [1:0] {IDLE, MEM_ACC, IO_ACC, DONE} state_t;
  typedef enum logic {CPU, LDR} owner_t;

  localparam logic [31:0] LED_ADDR        = 32'hFFFFFC60;
  localparam logic [31:0] SWITCH_ADDR     = 32'hFFFFFC70;
  localparam logic [31:0] SEG_ADDR        = 32'hFFFFFC80;
  localparam logic [21:0] IO_BASE_DEFAULT = 22'h3FFFFF;

endpackage

// File: rtl/io_addr_decode.sv
// rtl/io_addr_decode.sv - combinational IO address to chip-select decode
module io_addr_decode
  import memio_pkg::*;
#(
  parameter logic [21:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic [31:0] addr,
  output logic        led_cs,
  output logic        switch_cs,
  output logic        seg_cs,
  output logic        unmapped
);

  assign led_cs    = (addr == LED_ADDR);
  assign switch_cs = (addr == SWITCH_ADDR);
  assign seg_cs    = (addr == SEG_ADDR);
  assign unmapped  = (addr[31:10] == IO_BASE) & ~(led_cs | switch_cs | seg_cs);

endmodule

// File: rtl/mem_io_arbiter.sv
// rtl/mem_io_arbiter.sv - CPU/loader arbiter for data RAM and memory-mapped IO
// Optional MEMIO_BUS_ERR_EN: unmapped IO flags bus_err, returns ERR_DATA, no strobes.
module mem_io_arbiter
  import memio_pkg::*;
#(
  parameter int unsigned IO_WAIT  = 1,
  parameter logic [21:0] IO_BASE  = IO_BASE_DEFAULT,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        io_rd,
  output logic        io_wr,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  output logic        led_cs,
  output logic        switch_cs,
  output logic        seg_cs,
  output logic        bus_err
);

  state_t      state;
  owner_t      owner_q, rr_last;
  logic        we_q, io_q, unm_q;
  logic [3:0]  wcnt;
  logic [31:0] rdata_q;

  logic        grant_ldr, nxt_we, nxt_io;
  logic [31:0] nxt_addr, nxt_wdata;
  logic        dec_led, dec_sw, dec_seg, dec_unm;

  // Loader wins when alone, or when both ask and the CPU had the last grant.
  assign grant_ldr = ld_req & (~cpu_req | (rr_last == CPU));
  assign nxt_addr  = grant_ldr ? ld_addr  : cpu_addr;
  assign nxt_wdata = grant_ldr ? ld_wdata : cpu_wdata;
  assign nxt_we    = grant_ldr | cpu_we;
  assign nxt_io    = ~grant_ldr & (cpu_addr[31:10] == IO_BASE);

  io_addr_decode #(.IO_BASE(IO_BASE)) u_decode (
    .addr      (nxt_addr),
    .led_cs    (dec_led),
    .switch_cs (dec_sw),
    .seg_cs    (dec_seg),
    .unmapped  (dec_unm)
  );

  // RAM data arrives during DONE, so a memory load bypasses the holding register.
  assign cpu_rdata = (state == DONE && !io_q && !we_q && owner_q == CPU) ? mem_rdata : rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

`ifdef MEMIO_BUS_ERR_EN
  localparam logic [31:0] UNMAPPED_RDATA = ERR_DATA;
`else
  localparam logic [31:0] UNMAPPED_RDATA = 32'h0;
  logic unused_err_data;
  assign unused_err_data = ^ERR_DATA;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_last   <= CPU;
      owner_q   <= CPU;
      we_q      <= 1'b0;
      io_q      <= 1'b0;
      unm_q     <= 1'b0;
      wcnt      <= 4'd0;
      rdata_q   <= 32'h0;
      cpu_ack   <= 1'b0;
      ld_ack    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 14'h0;
      mem_wdata <= 32'h0;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
      io_wdata  <= 16'h0;
      led_cs    <= 1'b0;
      switch_cs <= 1'b0;
      seg_cs    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ld_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req | ld_req) begin
            owner_q <= grant_ldr ? LDR : CPU;
            rr_last <= grant_ldr ? LDR : CPU;
            we_q    <= nxt_we;
            io_q    <= nxt_io;
            unm_q   <= nxt_io & dec_unm;
            if (nxt_io) begin
              state     <= IO_ACC;
              wcnt      <= 4'(IO_WAIT);
              led_cs    <= dec_led;
              switch_cs <= dec_sw;
              seg_cs    <= dec_seg;
              io_wdata  <= nxt_wdata[15:0];
`ifdef MEMIO_BUS_ERR_EN
              io_rd <= ~nxt_we & ~dec_unm;
              io_wr <= nxt_we & ~dec_unm;
              if (dec_unm) bus_err <= 1'b1;
`else
              io_rd <= ~nxt_we;
              io_wr <= nxt_we;
`endif
            end else begin
              state     <= MEM_ACC;
              mem_en    <= 1'b1;
              mem_we    <= nxt_we;
              mem_addr  <= nxt_addr[15:2];
              mem_wdata <= nxt_wdata;
            end
          end
        end
        MEM_ACC: begin
          state     <= DONE;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= 14'h0;
          mem_wdata <= 32'h0;
          cpu_ack   <= (owner_q == CPU);
          ld_ack    <= (owner_q == LDR);
        end
        IO_ACC: begin
          if (wcnt == 4'd0) begin
            state     <= DONE;
            io_rd     <= 1'b0;
            io_wr     <= 1'b0;
            io_wdata  <= 16'h0;
            led_cs    <= 1'b0;
            switch_cs <= 1'b0;
            seg_cs    <= 1'b0;
            cpu_ack   <= (owner_q == CPU);
            ld_ack    <= (owner_q == LDR);
            if (!we_q) rdata_q <= unm_q ? UNMAPPED_RDATA : {16'h0, io_rdata};
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!io_q && !we_q && owner_q == CPU) rdata_q <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_arbiter.sv
// tb/tb_mem_io_arbiter.sv - directed self-checking bench for mem_io_arbiter
module tb_mem_io_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        ld_req;
  logic [31:0] ld_addr, ld_wdata;
  logic        ld_ack;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        io_rd, io_wr;
  logic [15:0] io_wdata, io_rdata;
  logic        led_cs, switch_cs, seg_cs, bus_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:15] = '{4: 32'h12345678, default: 32'h0};

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[3:0]];
    end
  end

  mem_io_arbiter #(.IO_WAIT(1)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .led_cs(led_cs), .switch_cs(switch_cs), .seg_cs(seg_cs), .bus_err(bus_err)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 1'b0; ld_addr = '0; ld_wdata = '0; io_rdata = '0;
    tick; tick;
    chk("rst_cpu_ack", cpu_ack, 0);   chk("rst_ld_ack", ld_ack, 0);
    chk("rst_mem_en", mem_en, 0);     chk("rst_mem_addr", mem_addr, 0);
    chk("rst_io_rd", io_rd, 0);       chk("rst_io_wr", io_wr, 0);
    chk("rst_led_cs", led_cs, 0);     chk("rst_io_wdata", io_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_bus_err", bus_err, 0);
    reset = 1'b0;
    tick;

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    tick;
    chk("ld_mem_en", mem_en, 1);      chk("ld_mem_we", mem_we, 0);
    chk("ld_mem_addr", mem_addr, 4);  chk("ld_early_ack", cpu_ack, 0);
    chk("ld_stall", cpu_stall, 1);
    tick;
    chk("ld_ack", cpu_ack, 1);        chk("ld_rdata", cpu_rdata, 32'h12345678);
    chk("ld_mem_en_off", mem_en, 0);  chk("ld_no_ldack", ld_ack, 0);
    chk("ld_stall_off", cpu_stall, 0);
    cpu_req = 1'b0;
    tick;
    chk("ld_ack_pulse", cpu_ack, 0);  chk("ld_rdata_hold", cpu_rdata, 32'h12345678);

    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_FC60; cpu_wdata = 32'h0000_ABCD;
    tick;
    chk("st_led_cs1", led_cs, 1);     chk("st_io_wr1", io_wr, 1);
    chk("st_io_rd", io_rd, 0);        chk("st_io_wdata", io_wdata, 16'hABCD);
    chk("st_ack1", cpu_ack, 0);       chk("st_mem_en", mem_en, 0);
    tick;
    chk("st_led_cs2", led_cs, 1);     chk("st_io_wr2", io_wr, 1);
    chk("st_ack2", cpu_ack, 0);
    tick;
    chk("st_ack", cpu_ack, 1);        chk("st_led_off", led_cs, 0);
    chk("st_io_wr_off", io_wr, 0);    chk("st_rdata_keep", cpu_rdata, 32'h12345678);
    cpu_req = 1'b0;
    tick;

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_FC70; io_rdata = 16'h00F0;
    tick;
    chk("sw_cs", switch_cs, 1);       chk("sw_io_rd1", io_rd, 1);
    chk("sw_led_off", led_cs, 0);
    tick;
    chk("sw_io_rd2", io_rd, 1);       chk("sw_ack2", cpu_ack, 0);
    tick;
    chk("sw_ack", cpu_ack, 1);        chk("sw_rdata", cpu_rdata, 32'h0000_00F0);
    chk("sw_cs_off", switch_cs, 0);
    cpu_req = 1'b0;
    tick;

    cpu_addr = 32'hFFFF_FC90; io_rdata = 16'h5555; cpu_req = 1'b1;
    tick;
    chk("un_led", led_cs, 0); chk("un_sw", switch_cs, 0); chk("un_seg", seg_cs, 0);
`ifdef MEMIO_BUS_ERR_EN
    chk("un_io_rd", io_rd, 0);        chk("un_bus_err", bus_err, 1);
`else
    chk("un_io_rd", io_rd, 1);        chk("un_bus_err", bus_err, 0);
`endif
    tick; tick;
    chk("un_ack", cpu_ack, 1);
`ifdef MEMIO_BUS_ERR_EN
    chk("un_rdata", cpu_rdata, 32'hDEADBEEF);
`else
    chk("un_rdata", cpu_rdata, 32'h0);
`endif
    cpu_req = 1'b0;
    tick;
`ifdef MEMIO_BUS_ERR_EN
    chk("un_bus_err_sticky", bus_err, 1);
`else
    chk("un_bus_err_tied", bus_err, 0);
`endif

    ld_addr = 32'h0000_0020; ld_wdata = 32'hCAFEF00D; ld_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 32'h0000_0020; cpu_req = 1'b1;
    tick;
    chk("rr1_mem_en", mem_en, 1);     chk("rr1_mem_we", mem_we, 1);
    chk("rr1_mem_addr", mem_addr, 8); chk("rr1_mem_wdata", mem_wdata, 32'hCAFEF00D);
    tick;
    chk("rr1_ld_ack", ld_ack, 1);     chk("rr1_cpu_ack", cpu_ack, 0);
    chk("rr1_stall", cpu_stall, 1);
    ld_addr = 32'h0000_0024; ld_wdata = 32'h1111_0000;
    tick;
    chk("rr_idle_mem_en", mem_en, 0); chk("rr_idle_ld_ack", ld_ack, 0);
    tick;
    chk("rr2_mem_en", mem_en, 1);     chk("rr2_mem_we", mem_we, 0);
    chk("rr2_mem_addr", mem_addr, 8);
    tick;
    chk("rr2_cpu_ack", cpu_ack, 1);   chk("rr2_ld_ack", ld_ack, 0);
    chk("rr2_rdata", cpu_rdata, 32'hCAFEF00D);
    cpu_req = 1'b0;
    tick;
    chk("rr_idle2_mem_en", mem_en, 0);
    tick;
    chk("rr3_mem_we", mem_we, 1);     chk("rr3_mem_addr", mem_addr, 9);
    chk("rr3_mem_wdata", mem_wdata, 32'h1111_0000);
    tick;
    chk("rr3_ld_ack", ld_ack, 1);     chk("rr3_cpu_ack", cpu_ack, 0);
    ld_req = 1'b0;
    tick;

    cpu_addr = 32'hFFFF_FC80; cpu_we = 1'b0; cpu_req = 1'b1;
    tick;
    chk("ab_seg_cs", seg_cs, 1);      chk("ab_io_rd", io_rd, 1);
    reset = 1'b1; cpu_req = 1'b0;
    tick;
    chk("ab_seg_off", seg_cs, 0);     chk("ab_io_rd_off", io_rd, 0);
    chk("ab_ack", cpu_ack, 0);        chk("ab_rdata", cpu_rdata, 0);
    chk("ab_mem_en", mem_en, 0);      chk("ab_bus_err", bus_err, 0);
    reset = 1'b0;
    tick;
    chk("ab_no_late_ack", cpu_ack, 0);

    cpu_addr = 32'h0000_0010; cpu_req = 1'b1;
    tick;
    chk("fr_mem_en", mem_en, 1);      chk("fr_mem_addr", mem_addr, 4);
    tick;
    chk("fr_ack", cpu_ack, 1);        chk("fr_rdata", cpu_rdata, 32'h12345678);
    cpu_req = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
